// File: rtl/ccip_c0rd_arbiter_if.sv
// Signal bundle between AFU read engines, the C0 read arbiter and the CCI-P C0 port.
// The arbiter uses the slave modport; the AFU/port side drives through master.
interface ccip_c0rd_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 42
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*12-1:0]     req_tag;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      C0TxAlmFull;
    logic                      C0TxRdValid;
    logic [ADDR_W-1:0]         C0TxAddr;
    logic [15:0]               C0TxMdata;
    logic                      C0RxRdValid;
    logic [15:0]               C0RxMdata;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [11:0]               rsp_tag;
    logic                      drain_req;
    logic                      drained;
    logic [15:0]               outst_total;
    logic                      err_underflow;

    modport master (
        output req_valid, req_addr, req_tag, C0TxAlmFull, C0RxRdValid, C0RxMdata, drain_req,
        input  req_ready, C0TxRdValid, C0TxAddr, C0TxMdata, rsp_valid, rsp_tag, drained,
               outst_total, err_underflow
    );

    modport slave (
        input  req_valid, req_addr, req_tag, C0TxAlmFull, C0RxRdValid, C0RxMdata, drain_req,
        output req_ready, C0TxRdValid, C0TxAddr, C0TxMdata, rsp_valid, rsp_tag, drained,
               outst_total, err_underflow
    );
endinterface

// File: rtl/ccip_c0rd_arbiter.sv
// Round-robin arbiter sharing the CCI-P C0 read-request channel between NUM_REQ requesters,
// with per-requester outstanding tracking, response routing by mdata[15:12] and a drain mode.
module ccip_c0rd_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int MAX_OUTST = 32,
    parameter int ADDR_W    = 42
) (
    input logic                clk,
    input logic                SoftReset,
    ccip_c0rd_arbiter_if.slave bus
);
    localparam int IDX_W = 4;
    localparam int CNT_W = $clog2(MAX_OUTST) + 1;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        IDLE  = 2'd2
    } state_t;

    state_t             state_r;
    logic [CNT_W-1:0]   cnt_r [NUM_REQ];
    logic [CNT_W-1:0]   cntNext_s [NUM_REQ];
    logic [IDX_W-1:0]   rrPtr_r;
    logic [NUM_REQ-1:0] eligible_s;
    logic [NUM_REQ-1:0] grant_s;
    logic [IDX_W-1:0]   grantIdx_s;
    logic               accept_s;
    logic [NUM_REQ-1:0] rspHit_s;
    logic               rxOk_s;
    logic               rxErr_s;
    logic [15:0]        totalNext_s;
    logic               allZeroNext_s;

    logic               txValid_r;
    logic [ADDR_W-1:0]  txAddr_r;
    logic [15:0]        txMdata_r;
    logic [NUM_REQ-1:0] rspValid_r;
    logic [11:0]        rspTag_r;
    logic               drained_r;
    logic [15:0]        outstTotal_r;
    logic               errUnderflow_r;

    // Per-requester eligibility; the raw reset input keeps req_ready low while reset is held.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible_s[i] = bus.req_valid[i] && (cnt_r[i] < CNT_W'(MAX_OUTST)) &&
                            (state_r == RUN) && !bus.drain_req && !bus.C0TxAlmFull && !SoftReset;
        end
    end

    // Round-robin pick: scan downwards so the nearest eligible requester at/after rrPtr wins.
    always_comb begin
        grant_s    = '0;
        grantIdx_s = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (eligible_s[(int'(rrPtr_r) + k) % NUM_REQ]) begin
                grant_s = '0;
                grant_s[(int'(rrPtr_r) + k) % NUM_REQ] = 1'b1;
                grantIdx_s = IDX_W'((int'(rrPtr_r) + k) % NUM_REQ);
            end else begin
                grant_s = grant_s;
            end
        end
    end

    assign accept_s = |grant_s;

    // Response decode; out-of-range indices never match any requester and so count as errors.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            rspHit_s[i] = bus.C0RxRdValid && (bus.C0RxMdata[15:12] == IDX_W'(i)) &&
                          (cnt_r[i] != '0);
        end
        rxOk_s  = |rspHit_s;
        rxErr_s = bus.C0RxRdValid && !rxOk_s;
    end

    // Next outstanding counts and their total; a same-cycle issue and return cancel out.
    always_comb begin
        totalNext_s   = '0;
        allZeroNext_s = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            case ({grant_s[i], rspHit_s[i]})
                2'b10:   cntNext_s[i] = cnt_r[i] + CNT_W'(1);
                2'b01:   cntNext_s[i] = cnt_r[i] - CNT_W'(1);
                default: cntNext_s[i] = cnt_r[i];
            endcase
            totalNext_s   = totalNext_s + 16'(cntNext_s[i]);
            allZeroNext_s = allZeroNext_s & (cntNext_s[i] == '0);
        end
    end

    // Counters, issue register, response register and the RUN/DRAIN/IDLE controller.
    always_ff @(posedge clk or posedge SoftReset) begin
        if (SoftReset) begin
            state_r        <= RUN;
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt_r[i] <= '0;
            end
            rrPtr_r        <= '0;
            txValid_r      <= 1'b0;
            txAddr_r       <= '0;
            txMdata_r      <= 16'h0000;
            rspValid_r     <= '0;
            rspTag_r       <= 12'h000;
            drained_r      <= 1'b0;
            outstTotal_r   <= 16'h0000;
            errUnderflow_r <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt_r[i] <= cntNext_s[i];
            end
            outstTotal_r <= totalNext_s;
            txValid_r    <= accept_s;
            if (accept_s) begin
                rrPtr_r   <= (grantIdx_s == IDX_W'(NUM_REQ - 1)) ? IDX_W'(0) : grantIdx_s + IDX_W'(1);
                txAddr_r  <= bus.req_addr[int'(grantIdx_s) * ADDR_W +: ADDR_W];
                txMdata_r <= {grantIdx_s, bus.req_tag[int'(grantIdx_s) * 12 +: 12]};
            end
            rspValid_r <= rspHit_s;
            if (rxOk_s) begin
                rspTag_r <= bus.C0RxMdata[11:0];
            end
            if (rxErr_s) begin
                errUnderflow_r <= 1'b1;
            end
            // Quiescence is judged on next-cycle counts so drained rises right after the last return.
            case (state_r)
                RUN: begin
                    if (bus.drain_req) begin
                        state_r <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!bus.drain_req) begin
                        state_r <= RUN;
                    end else if (allZeroNext_s && !accept_s) begin
                        state_r   <= IDLE;
                        drained_r <= 1'b1;
                    end
                end
                IDLE: begin
                    if (!bus.drain_req) begin
                        state_r   <= RUN;
                        drained_r <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= RUN;
                    drained_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready     = grant_s;
    assign bus.C0TxRdValid   = txValid_r;
    assign bus.C0TxAddr      = txAddr_r;
    assign bus.C0TxMdata     = txMdata_r;
    assign bus.rsp_valid     = rspValid_r;
    assign bus.rsp_tag       = rspTag_r;
    assign bus.drained       = drained_r;
    assign bus.outst_total   = outstTotal_r;
    assign bus.err_underflow = errUnderflow_r;
endmodule

// File: doc/ccip_c0rd_arbiter.md
Name: ccip_c0rd_arbiter

Overview:
- Shares the CCI-P C0 Tx read-request channel between NUM_REQ AFU-side requesters using round-robin arbitration.
- Tags each issued request's mdata with the requester index, tracks outstanding reads per requester, and routes C0 Rx read responses back to the owning requester.
- Provides a drain mode so the AFU can quiesce reads before SoftReset or reconfiguration.
- Sits between AFU read engines and the C0TxHdr/C0TxRdValid and C0RxHdr/C0RxRdValid port signals.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- MAX_OUTST, 32, maximum outstanding reads per requester (power of 2, <=256).
- ADDR_W, 42, cache-line address width.

Ports:
- clk  in  1  CCI-P clock.
- SoftReset  in  1  asynchronous active-high reset.
- req_valid  in  NUM_REQ  per-requester read request.
- req_addr  in  NUM_REQ*ADDR_W  request addresses; requester i occupies bits [i*ADDR_W +: ADDR_W].
- req_tag  in  NUM_REQ*12  requester-private tag; requester i occupies bits [i*12 +: 12].
- req_ready  out  NUM_REQ  one-hot grant.
- C0TxAlmFull  in  1  Tx0 almost full.
- C0TxRdValid  out  1  read request valid.
- C0TxAddr  out  ADDR_W  issued address.
- C0TxMdata  out  16  {req index[3:0], req_tag[11:0]}.
- C0RxRdValid  in  1  read response valid.
- C0RxMdata  in  16  response mdata.
- rsp_valid  out  NUM_REQ  one-hot response strobe.
- rsp_tag  out  12  returned tag.
- drain_req  in  1  level request to stop issuing.
- drained  out  1  drain complete.
- outst_total  out  NUM_REQ*8 ... no: 16  total outstanding reads, all requesters.
- err_underflow  out  1  sticky: response seen with zero outstanding, or for index >= NUM_REQ.

Behaviour:
- Reset: all outputs 0, counters 0, RR pointer 0, FSM in RUN. Reset takes effect immediately (asynchronous). In-flight responses arriving after reset are flagged as errors only if the target counter is 0.
- Eligibility: requester i is eligible when req_valid[i]=1, its counter cnt[i] < MAX_OUTST, FSM=RUN, and C0TxAlmFull=0.
- req_ready is combinational. At most one bit is set: the first eligible requester at or after the RR pointer, searching in increasing order with wrap.
- Handshake: a request is accepted when req_valid[i] & req_ready[i] are both high.
- Acceptance effects:
  - Next cycle, C0TxRdValid=1 with the registered C0TxAddr and C0TxMdata (1-cycle latency).
  - The RR pointer moves to (i+1) mod NUM_REQ.
  - cnt[i] increments.
- With no acceptance, C0TxRdValid=0 next cycle and the C0TxAddr/C0TxMdata outputs hold their values.
- AlmFull: sampled combinationally. While it is high, no new grants are made; the single registered request already in flight still issues (within CCI-P slack).
- Response handling:
  - When C0RxRdValid=1, the index is C0RxMdata[15:12].
  - Next cycle, rsp_valid[index]=1 and rsp_tag=C0RxMdata[11:0] (1-cycle latency).
  - cnt[index] decrements.
  - If index >= NUM_REQ or cnt[index]=0: no rsp_valid is asserted, the counter is unchanged, and err_underflow is set (cleared only by reset).
- Simultaneous accept and response for the same requester: cnt is unchanged.
- outst_total is the registered sum of all cnt[i].
- FSM:
  - RUN: normal operation. If drain_req=1, go to DRAIN; no grant is made in that cycle.
  - DRAIN: no grants. When all cnt=0 and C0TxRdValid=0, go to IDLE.
  - IDLE: drained=1, no grants. If drain_req=0, go to RUN with drained=0 in the same cycle as the transition.
  - If drain_req drops while in DRAIN, return to RUN.
- Counter saturation: at cnt[i]=MAX_OUTST, requester i is ineligible. The RR search skips it and other requesters are not blocked.

Test Plan:
- Single request, 4 requesters: req_valid=0001, addr=0x100, tag=0x0AB -> req_ready=0001 the same cycle; next cycle C0TxRdValid=1, C0TxMdata=0x00AB, C0TxAddr=0x100, outst_total=1.
- Fairness: all 4 requesters hold req_valid=1 for 8 cycles -> grant order 0,1,2,3,0,1,2,3; outst_total=8.
- Back-pressure: raise C0TxAlmFull for 5 cycles with req_valid=1111 -> req_ready=0 in all 5 cycles; the grant resumes at the RR pointer once AlmFull falls.
- Response routing: C0RxRdValid with mdata=0x2123 after requester 2 has issued one request -> rsp_valid=0100 and rsp_tag=0x123 next cycle; cnt[2] goes back to 0.
- Saturation and error: requester 1 issues 32 reads with no response -> req_ready[1] stays 0 while requester 3 is still granted. Separately, a response with mdata=0x3000 while cnt[3]=0 -> err_underflow=1 and no rsp_valid.
- Drain: 3 reads outstanding, assert drain_req -> no grants; return the 3 responses -> drained=1 one cycle after the last response; deassert drain_req -> grants resume. Assert SoftReset mid-drain -> all outputs 0 asynchronously.
